jtl_line: RTL and testbench

Parametrised, clocked, multi-channel successor to the single-channel behavioural JTL cell. It carries WIDTH independent SFQ-pulse channels through a DEPTH-stage delay line, with per-channel enable masking, a post-reset startup blanking window, selectable toggle or return-to-zero output encoding, and per-channel pulse counters. It sits between SFQ cell models and cycle-based checkers, so pulse streams can be delayed, gated and counted in the same timebase as the assertion logic.

---
 rtl/jtl_line.sv | 101 ++++++++++
 tb/tb_jtl_line.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtl_line.sv
// jtl_line: multi-channel SFQ pulse delay line.
// Each channel turns toggle-encoded input edges into pulses and delays them
// through DEPTH register stages. Channels can be masked by an enable, and all
// channels are blanked for a short window after reset. The output is either
// toggle or return-to-zero encoded, and each channel counts its emitted pulses.
module jtl_line #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 3,
    parameter int STARTUP = 2,
    parameter int TOGGLE  = 1,
    parameter int CW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in,
    input  logic [WIDTH-1:0]    en,
    output logic [WIDTH-1:0]    out,
    output logic [WIDTH*CW-1:0] pulse_cnt,
    output logic                busy,
    output logic                ready
);

    // The startup counter needs enough bits to hold STARTUP. A zero-length
    // window still needs a 1-bit register, which simply stays at zero.
    localparam int SW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;

    logic [SW-1:0]    startup_cnt;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] stage [DEPTH];
    logic [WIDTH-1:0] accepted;
    logic [WIDTH-1:0] emerging;

    // ready uses the counter value from before the edge, so an edge sampled
    // on the same edge where the counter reaches zero is still absorbed.
    assign ready    = (startup_cnt == '0);
    assign accepted = (in ^ in_q) & en & {WIDTH{ready}};
    assign emerging = stage[DEPTH-1];

    // Count down the post-reset blanking window and then hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            startup_cnt <= SW'(STARTUP);
        end else if (!ready) begin
            startup_cnt <= startup_cnt - 1'b1;
        end
    end

    // Remember the last input level. During reset this absorbs a held
    // nonzero level, and while gated it stops a masked edge from being
    // replayed later.
    always_ff @(posedge clk) begin
        in_q <= in;
    end

    // Shift the accepted pulses through the delay stages. Reset discards
    // anything that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= accepted;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    // Drive the output from the last stage: invert for toggle encoding,
    // or copy it for a one-cycle return-to-zero pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (TOGGLE != 0) begin
            out <= out ^ emerging;
        end else begin
            out <= emerging;
        end
    end

    // Count emitted pulses per channel. Each counter wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                pulse_cnt[i*CW +: CW] <= pulse_cnt[i*CW +: CW] + CW'(emerging[i]);
            end
        end
    end

    // busy is high while any stage of any channel still holds a pulse.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | (|stage[k]);
        end
    end

endmodule

// File: tb/tb_jtl_line.sv
// Testbench for jtl_line. It drives two instances with the same stimulus:
// instance A uses toggle encoding with 8-bit counters, and instance B uses
// return-to-zero encoding with 2-bit counters. An event-time model predicts
// each output on every cycle, and directed literal checks pin that model.
module tb_jtl_line;

    localparam int W = 4;
    localparam int D = 3;
    localparam int S = 2;

    logic            clk;
    logic            rst;
    logic [W-1:0]    stimIn;
    logic [W-1:0]    stimEn;
    logic [W-1:0]    outA;
    logic [W*8-1:0]  cntA;
    logic            busyA;
    logic            readyA;
    logic [W-1:0]    outB;
    logic [W*2-1:0]  cntB;
    logic            busyB;
    logic            readyB;

    int  checkCount;
    int  passCount;
    bit  checkEnable;

    // Model state: the absolute emission edge of each in-flight pulse,
    // the number of pulses emitted so far, and the readiness after each edge.
    int       edgeNum;
    int       sinceRelease;
    bit       modelReady;
    logic [W-1:0] lastIn;
    int       emitQ [W][$];
    int       emits [W];
    bit       rzFlag [W];

    jtl_line #(.WIDTH(W), .DEPTH(D), .STARTUP(S), .TOGGLE(1), .CW(8)) dutA (
        .clk(clk), .rst(rst), .in(stimIn), .en(stimEn),
        .out(outA), .pulse_cnt(cntA), .busy(busyA), .ready(readyA)
    );

    jtl_line #(.WIDTH(W), .DEPTH(D), .STARTUP(S), .TOGGLE(0), .CW(2)) dutB (
        .clk(clk), .rst(rst), .in(stimIn), .en(stimEn),
        .out(outB), .pulse_cnt(cntB), .busy(busyB), .ready(readyB)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Set the inputs for the next rising edge, then return just after that
    // edge so the caller sees the state it produced.
    task automatic applyStimulus(input logic [W-1:0] inVal, input logic [W-1:0] enVal,
                                 input logic rstVal);
        stimIn = inVal;
        stimEn = enVal;
        rst    = rstVal;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: each accepted edge becomes an emission scheduled D
    // edges later. Outputs and counts follow from the emission history.
    initial begin
        edgeNum      = 0;
        sinceRelease = 0;
        modelReady   = 1'b0;
        lastIn       = '0;
        forever begin
            @(posedge clk);
            edgeNum++;
            if (rst) begin
                for (int c = 0; c < W; c++) begin
                    emitQ[c].delete();
                    emits[c]  = 0;
                    rzFlag[c] = 1'b0;
                end
                lastIn       = stimIn;
                sinceRelease = 0;
                modelReady   = (S == 0);
            end else begin
                for (int c = 0; c < W; c++) begin
                    if (stimIn[c] != lastIn[c] && stimEn[c] && modelReady) begin
                        emitQ[c].push_back(edgeNum + D);
                    end
                end
                lastIn = stimIn;
                for (int c = 0; c < W; c++) begin
                    rzFlag[c] = 1'b0;
                    if (emitQ[c].size() > 0 && emitQ[c][0] == edgeNum) begin
                        void'(emitQ[c].pop_front());
                        emits[c]++;
                        rzFlag[c] = 1'b1;
                    end
                end
                sinceRelease++;
                modelReady = (sinceRelease >= S);
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    initial begin
        logic [W-1:0]   expOutA;
        logic [W-1:0]   expOutB;
        logic [W*8-1:0] expCntA;
        logic [W*2-1:0] expCntB;
        logic           expBusy;
        forever begin
            @(negedge clk);
            if (checkEnable) begin
                expBusy = 1'b0;
                for (int c = 0; c < W; c++) begin
                    expOutA[c]       = emits[c][0];
                    expOutB[c]       = rzFlag[c];
                    expCntA[c*8 +: 8] = emits[c][7:0];
                    expCntB[c*2 +: 2] = emits[c][1:0];
                    if (emitQ[c].size() > 0) expBusy = 1'b1;
                end
                checkOutput("A.out",   32'(outA),   32'(expOutA));
                checkOutput("A.cnt",   32'(cntA),   32'(expCntA));
                checkOutput("A.busy",  32'(busyA),  32'(expBusy));
                checkOutput("A.ready", 32'(readyA), 32'(modelReady));
                checkOutput("B.out",   32'(outB),   32'(expOutB));
                checkOutput("B.cnt",   32'(cntB),   32'(expCntB));
                checkOutput("B.busy",  32'(busyB),  32'(expBusy));
                checkOutput("B.ready", 32'(readyB), 32'(modelReady));
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int wrapSeq [5];
        logic [W-1:0] v;
        wrapSeq = '{1, 2, 3, 0, 1};
        checkCount  = 0;
        passCount   = 0;
        checkEnable = 1'b0;

        // A nonzero level held through reset must not turn into a pulse.
        applyStimulus(4'b1010, 4'b1111, 1'b1);
        checkEnable = 1'b1;
        applyStimulus(4'b1010, 4'b1111, 1'b1);
        checkOutput("reset.out",   32'(outA),   32'h0);
        checkOutput("reset.cnt",   cntA,        32'h0);
        checkOutput("reset.busy",  32'(busyA),  32'h0);
        checkOutput("reset.ready", 32'(readyA), 32'h0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("release1.ready", 32'(readyA), 32'h0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("release2.ready", 32'(readyA), 32'h1);
        for (int j = 0; j < 8; j++) applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("hold.outA", 32'(outA), 32'h0);
        checkOutput("hold.cntA", cntA,      32'h0);
        checkOutput("hold.outB", 32'(outB), 32'h0);

        // A single edge on channel 0 emerges three edges later.
        applyStimulus(4'b1011, 4'b1111, 1'b0);
        checkOutput("delay.busy0", 32'(busyA), 32'h1);
        applyStimulus(4'b1011, 4'b1111, 1'b0);
        checkOutput("delay.busy1", 32'(busyA), 32'h1);
        applyStimulus(4'b1011, 4'b1111, 1'b0);
        checkOutput("delay.busy2", 32'(busyA), 32'h1);
        checkOutput("delay.early", 32'(outA),  32'h0);
        applyStimulus(4'b1011, 4'b1111, 1'b0);
        checkOutput("delay.outA",  32'(outA),      32'h1);
        checkOutput("delay.cntA",  32'(cntA[7:0]), 32'h1);
        checkOutput("delay.busy3", 32'(busyA),     32'h0);
        checkOutput("delay.outB",  32'(outB),      32'h1);
        checkOutput("delay.cntB",  32'(cntB[1:0]), 32'h1);
        applyStimulus(4'b1011, 4'b1111, 1'b0);
        checkOutput("delay.rzLow", 32'(outB), 32'h0);
        checkOutput("delay.hold",  32'(outA), 32'h1);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        for (int j = 0; j < 3; j++) applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("delay2.outA", 32'(outA),      32'h0);
        checkOutput("delay2.cntA", 32'(cntA[7:0]), 32'h2);

        // An edge inside the blanking window is lost for good. An edge
        // after the window is delivered.
        applyStimulus(4'b1010, 4'b1111, 1'b1);
        applyStimulus(4'b1000, 4'b1111, 1'b0);
        applyStimulus(4'b1000, 4'b1111, 1'b0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("blank.cnt1", 32'(cntA[15:8]), 32'h0);
        checkOutput("blank.out1", 32'(outA),       32'h0);
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("blank.late.out", 32'(outA),       32'h2);
        checkOutput("blank.late.cnt", 32'(cntA[15:8]), 32'h1);

        // Mask channels 1 and 3, then toggle every input on four consecutive edges.
        applyStimulus(4'b0000, 4'b0101, 1'b1);
        applyStimulus(4'b0000, 4'b0101, 1'b0);
        applyStimulus(4'b0000, 4'b0101, 1'b0);
        for (int j = 0; j < 8; j++) begin
            v = (j < 4 && (j % 2) == 0) ? 4'b1111 : 4'b0000;
            applyStimulus(v, 4'b0101, 1'b0);
            if (j >= 3 && j <= 6) checkOutput("rz.high", 32'(outB), 32'h5);
            else                  checkOutput("rz.low",  32'(outB), 32'h0);
        end
        checkOutput("rz.cntA", cntA,      32'h00040004);
        checkOutput("rz.outA", 32'(outA), 32'h0);

        // Five back-to-back pulses on channel 3 wrap the 2-bit counter.
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        for (int j = 0; j < 8; j++) begin
            v = (j < 5) ? (((j % 2) == 0) ? 4'b1000 : 4'b0000) : 4'b1000;
            applyStimulus(v, 4'b1111, 1'b0);
            if (j >= 3) checkOutput("wrap.cnt3", 32'(cntB[7:6]), 32'(wrapSeq[j-3]));
        end
        checkOutput("wrap.cntA3", 32'(cntA[31:24]), 32'h5);

        // A reset while pulses are in flight discards them.
        applyStimulus(4'b1001, 4'b1111, 1'b0);
        applyStimulus(4'b1000, 4'b1111, 1'b0);
        checkOutput("mid.inflight", 32'(busyA), 32'h1);
        applyStimulus(4'b1000, 4'b1111, 1'b1);
        checkOutput("mid.outA",  32'(outA),  32'h0);
        checkOutput("mid.busy",  32'(busyA), 32'h0);
        checkOutput("mid.cntA",  cntA,       32'h0);
        checkOutput("mid.cntB",  32'(cntB),  32'h0);
        for (int j = 0; j < 8; j++) applyStimulus(4'b1000, 4'b1111, 1'b0);
        checkOutput("mid.late.out", 32'(outA), 32'h0);
        checkOutput("mid.late.cnt", cntA,      32'h0);

        checkEnable = 1'b0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
